tdc_decoder: RTL
================

Name: tdc_decoder

Overview:
- Digital back end of the analog TDC interface.
- Samples the TDC ripple counter and the 16-tap ring-phase word each clk cycle.
- Decodes the phase word into a 5-bit fractional DCO-period position and forms the 12-bit variable-phase word tdc_word = {ripple_count, frac}.
- Also produces a modulo cycle-to-cycle phase delta and flags/counts invalid (bubbled) phase codes.
- Feeds the ADPLL phase detector in place of the simulation-driven tdc_word.

Parameters:
- PHASE_W, 16, number of ring-phase taps; fixed to 16 in this revision.
- RC_W, 7, ripple counter width.
- WORD_W, 12, output word width; equals RC_W + 5.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system reference clock; all sampling on posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  decoder enable.
- tdc_ripple_count  in  RC_W  DCO-period ripple count from analog TDC.
- tdc_phase  in  PHASE_W  sampled ring-tap thermometer from analog TDC.
- tdc_word  out  WORD_W  decoded phase word.
- tdc_word_valid  out  1  tdc_word is current.
- tdc_delta  out  WORD_W  tdc_word minus previous tdc_word, mod 2^WORD_W.
- tdc_delta_valid  out  1  tdc_delta is current.
- code_err  out  1  one-cycle pulse when the current code is invalid.
- err_count  out  ERR_CNT_W  saturating count of invalid codes since reset.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0; FSM to IDLE; input and previous-word registers cleared.
- Pipeline:
  - Stage 1 registers tdc_ripple_count and tdc_phase every cycle.
  - Stage 2 decodes and registers the outputs.
  - Inputs present at posedge n appear on the outputs after posedge n+1, i.e. latency 2 clocks.
- Phase classification of stage-1 phase p, for k = 0..15:
  - Class A: p == 2^k−1 (low k bits one, rest zero) gives frac = k. All-zeros gives frac 0.
  - Class B: p == ~(2^k−1) (low k bits zero, rest one) gives frac = 16+k. All-ones gives frac 16; 0x8000 gives frac 31.
  - Any other value is invalid.
- tdc_word = {rc, frac}, i.e. rc*32 + frac.
- Invalid code:
  - tdc_word holds its previous value and valid flags keep their state.
  - code_err pulses 1 cycle.
  - err_count increments and saturates at 2^ERR_CNT_W−1.
  - tdc_delta is computed against the held word, giving delta 0.
- FSM:
  - IDLE: outputs word/delta/valids = 0. Go to PRIME when en=1.
  - PRIME: first decoded sample. tdc_word_valid=1, tdc_delta_valid=0. Store the word as prev. Go to RUN.
  - RUN: each cycle tdc_delta = (word − prev) mod 4096 with tdc_delta_valid=1, then prev ← word.
  - en=0 in any state: next cycle go to IDLE and clear word/delta/valids. err_count is retained.
  - Entry to PRIME is gated by the 2-cycle pipeline: the first valid output follows the first posedge at which en=1 by 2 cycles.
- Ripple counter wrap: the 12-bit modulo subtraction makes rc 127→0 transitions produce a small positive delta with no special casing.
- Invalid code in PRIME: stays in PRIME with tdc_word_valid=0 until the first valid code.
- Reset asserted mid-RUN: immediate clear and IDLE regardless of clk.

Optional Feature:
- Macro: TDC_BUBBLE_FIX_EN.
- When defined:
  - Before classification, stage-1 phase passes a 3-tap majority filter: p'[i] = maj(p[i−1], p[i], p[i+1]), with p[−1]=p[0] and p[16]=p[15].
  - Classification uses p'.
  - code_err and err_count fire only if p' is still invalid.
  - Latency is unchanged; the filter is in the stage-2 combinational path.
- When undefined: classification uses raw p; any bubble is an error.

Test Plan:
- Reset: rst_n=0 with random inputs → all outputs 0, err_count=0; release, en=0 → outputs stay 0.
- Basic decode: en=1, rc=5, phase=0x0007 → 2 clocks later tdc_word=163, tdc_word_valid=1, tdc_delta_valid=0. Next sample rc=5, phase=0xFFF8 → tdc_word=179, tdc_delta=16, tdc_delta_valid=1.
- Wrap: rc=127, phase=0x8000 → tdc_word=4095. Next rc=0, phase=0x0001 → tdc_word=1, tdc_delta=2.
- Invalid code, macro undefined: phase=0x00F0 after word=179 → tdc_word stays 179, tdc_delta=0, code_err one pulse, err_count+1. 300 consecutive errors → err_count=255.
- Bubble fix, macro defined: rc=2, phase=0x0005 → p'=0x0003, tdc_word=66, no code_err. phase=0x00F0 → still invalid, code_err pulses.
- Enable drop/reset mid-run: en 1→0 in RUN → next cycle valids=0, word=0, err_count kept; re-enable re-enters PRIME. Async rst_n low between edges → outputs 0 immediately.

Source files
------------

// File: rtl/tdc_decoder.sv
// Digital back end of the analog TDC: samples ripple count and ring-phase taps, decodes them
// into {ripple_count, frac}, and produces a modulo phase delta plus invalid-code reporting.
// Optional build macro TDC_BUBBLE_FIX_EN adds a 3-tap majority filter ahead of classification.
module tdc_decoder #(
  parameter int PHASE_W   = 16,
  parameter int RC_W      = 7,
  parameter int WORD_W    = 12,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [RC_W-1:0]      tdc_ripple_count,
  input  logic [PHASE_W-1:0]   tdc_phase,
  output logic [WORD_W-1:0]    tdc_word,
  output logic                 tdc_word_valid,
  output logic [WORD_W-1:0]    tdc_delta,
  output logic                 tdc_delta_valid,
  output logic                 code_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [RC_W-1:0]      rc_q;
  logic [PHASE_W-1:0]   phase_q;
  logic [PHASE_W-1:0]   p_cls, p_inv;
  logic [PHASE_W+1:0]   p_ext;
  logic [4:0]           ones;
  logic                 is_a, is_b, code_ok;
  logic [4:0]           frac;
  logic [WORD_W-1:0]    word_new;

  logic [WORD_W-1:0]    word_q, word_d, delta_q, delta_d, prev_q, prev_d;
  logic                 wv_q, wv_d, dv_q, dv_d, err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  // Stage 1: raw sample of the analog interface, taken every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_q    <= '0;
      phase_q <= '0;
    end else begin
      rc_q    <= tdc_ripple_count;
      phase_q <= tdc_phase;
    end
  end

  always_comb begin
    p_ext = {phase_q[PHASE_W-1], phase_q, phase_q[0]};
    p_cls = phase_q;
`ifdef TDC_BUBBLE_FIX_EN
    for (int i = 0; i < PHASE_W; i++) begin
      p_cls[i] = (p_ext[i] & p_ext[i+1]) | (p_ext[i] & p_ext[i+2]) | (p_ext[i+1] & p_ext[i+2]);
    end
`endif
  end

  // A code is a low-ones mask (class A) or its complement (class B). For class B the fraction
  // is 16 + zero count = 32 - ones, which mod 32 is simply -ones.
  always_comb begin
    ones = '0;
    for (int i = 0; i < PHASE_W; i++) begin
      ones = ones + 5'(p_cls[i]);
    end
    p_inv    = ~p_cls;
    is_a     = ((p_cls & (p_cls + 16'd1)) == '0) && (p_cls != '1);
    is_b     = ((p_inv & (p_inv + 16'd1)) == '0) && (p_cls != '0);
    code_ok  = is_a || is_b;
    frac     = is_a ? ones : (5'd0 - ones);
    word_new = {rc_q, frac};
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    delta_d = delta_q;
    wv_d    = wv_q;
    dv_d    = dv_q;
    prev_d  = prev_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = IDLE;
      word_d  = '0;
      delta_d = '0;
      wv_d    = 1'b0;
      dv_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = PRIME;
        PRIME: begin
          if (code_ok) begin
            word_d  = word_new;
            prev_d  = word_new;
            wv_d    = 1'b1;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
        RUN: begin
          if (code_ok) begin
            word_d  = word_new;
            delta_d = word_new - prev_q;
            dv_d    = 1'b1;
            prev_d  = word_new;
          end else begin
            err_d   = 1'b1;
            delta_d = word_q - prev_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (err_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      delta_q <= '0;
      prev_q  <= '0;
      wv_q    <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      delta_q <= delta_d;
      prev_q  <= prev_d;
      wv_q    <= wv_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tdc_word        = word_q;
  assign tdc_word_valid  = wv_q;
  assign tdc_delta       = delta_q;
  assign tdc_delta_valid = dv_q;
  assign code_err        = err_q;
  assign err_count       = cnt_q;
  assign dbg_state       = state_q;

endmodule
